tug_of_war_core: RTL and testbench

- Parametrised tug-of-war game engine: two raw player keys in; LED rope position, per-player scores and match result out.
- Generalises the fixed 15-LED, single-round board to configurable rope length, debounce time, point hold time and match length.
- Adds a proper round/match state machine and simultaneous-press cancellation.
- Sits between the board key pins and the LED/7-segment display drivers.

---
 rtl/tug_of_war_core.sv | 165 ++++++++++++++++
 tb/tb_tug_of_war_core.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tug_of_war_core.sv
// Tug-of-war game engine: debounced player keys drive a one-hot rope position,
// with per-round scoring, a post-point freeze and a first-to-WIN_SCORE match.
module tug_of_war_core #(
    parameter int N_LED           = 15,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int WIN_SCORE       = 3,
    parameter int SCORE_W         = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               key_l,
    input  logic               key_r,
    output logic [N_LED-1:0]   led,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               point_l,
    output logic               point_r,
    output logic [1:0]         winner,
    output logic [1:0]         state
);

    localparam int PW = $clog2(N_LED);
    localparam int C  = (N_LED - 1) / 2;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t cur, nxt;

    // Index 0 is the left key, index 1 the right key.
    logic [1:0]    sync1, sync2, level, press;
    logic [DW-1:0] stable_cnt [2];

    logic [PW-1:0]      pos, pos_n;
    logic [HW-1:0]      hold_cnt, hold_n;
    logic [SCORE_W-1:0] score_l_n, score_r_n;
    logic [1:0]         winner_n;
    logic               point_l_n, point_r_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int unsigned k = 0; k < 2; k++) stable_cnt[k] <= '0;
        end else begin
            sync1 <= {key_r, key_l};
            sync2 <= sync1;
            press <= '0;
            for (int unsigned k = 0; k < 2; k++) begin
                if (sync2[k] == level[k]) begin
                    stable_cnt[k] <= '0;
                end else if (stable_cnt[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level[k]      <= sync2[k];
                    stable_cnt[k] <= '0;
                    press[k]      <= sync2[k];
                end else begin
                    stable_cnt[k] <= stable_cnt[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        nxt       = cur;
        pos_n     = pos;
        hold_n    = hold_cnt;
        score_l_n = score_l;
        score_r_n = score_r;
        winner_n  = winner;
        point_l_n = 1'b0;
        point_r_n = 1'b0;
        case (cur)
            IDLE: begin
                if (start) nxt = PLAY;
            end
            PLAY: begin
                if (press[0] && !press[1]) begin
                    if (pos == PW'(N_LED - 2)) begin
                        pos_n     = PW'(N_LED - 1);
                        score_l_n = score_l + 1'b1;
                        point_l_n = 1'b1;
                        hold_n    = '0;
                        nxt       = HOLD;
                    end else begin
                        pos_n = pos + 1'b1;
                    end
                end else if (press[1] && !press[0]) begin
                    if (pos == PW'(1)) begin
                        pos_n     = '0;
                        score_r_n = score_r + 1'b1;
                        point_r_n = 1'b1;
                        hold_n    = '0;
                        nxt       = HOLD;
                    end else begin
                        pos_n = pos - 1'b1;
                    end
                end
            end
            HOLD: begin
                // The goal LED stays lit in DONE, so pos recentres only on resuming play.
                if (hold_cnt == HW'(HOLD_CYCLES)) begin
                    if (score_l == SCORE_W'(WIN_SCORE)) begin
                        nxt      = DONE;
                        winner_n = 2'b01;
                    end else if (score_r == SCORE_W'(WIN_SCORE)) begin
                        nxt      = DONE;
                        winner_n = 2'b10;
                    end else begin
                        nxt   = PLAY;
                        pos_n = PW'(C);
                    end
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    score_l_n = '0;
                    score_r_n = '0;
                    winner_n  = 2'b00;
                    pos_n     = PW'(C);
                    nxt       = PLAY;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= IDLE;
            pos      <= PW'(C);
            hold_cnt <= '0;
            score_l  <= '0;
            score_r  <= '0;
            winner   <= 2'b00;
            point_l  <= 1'b0;
            point_r  <= 1'b0;
            led      <= N_LED'(1) << C;
        end else begin
            cur      <= nxt;
            pos      <= pos_n;
            hold_cnt <= hold_n;
            score_l  <= score_l_n;
            score_r  <= score_r_n;
            winner   <= winner_n;
            point_l  <= point_l_n;
            point_r  <= point_r_n;
            led      <= N_LED'(1) << pos_n;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_tug_of_war_core.sv
// Scoreboard bench for tug_of_war_core: a window-based key model and a plain
// game model predict every cycle's outputs, checked by an independent monitor.
module tb_tug_of_war_core;

    localparam int N = 7;
    localparam int D = 4;
    localparam int H = 8;
    localparam int W = 2;
    localparam int C = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1, start = 1'b0, key_l = 1'b0, key_r = 1'b0;
    logic [6:0] led;
    logic [1:0] score_l, score_r, winner, state;
    logic       point_l, point_r;

    always #5 clk = ~clk;

    tug_of_war_core #(
        .N_LED(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .WIN_SCORE(W), .SCORE_W(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .key_l(key_l), .key_r(key_r),
        .led(led), .score_l(score_l), .score_r(score_r),
        .point_l(point_l), .point_r(point_r), .winner(winner), .state(state)
    );

    typedef struct packed {
        logic [1:0] st;
        logic [6:0] led;
        logic [1:0] sl;
        logic [1:0] sr;
        logic       pl;
        logic       pr;
        logic [1:0] win;
    } obs_t;

    obs_t q[$];
    int   checks = 0;
    int   fails  = 0;

    // Reference model: mode uses the output encoding 0 idle, 1 play, 2 hold, 3 done.
    int mode, pos, sl, sr, win, held;
    bit pl, pr;
    bit acc[2];
    bit prs[2];
    bit hist[2][$];

    function automatic bit window_differs(int k);
        for (int i = 0; i < D; i++)
            if (hist[k][i] == acc[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step(input bit r, input bit s, input bit kl, input bit kr);
        bit   raw[2];
        obs_t e;
        int   mv;
        @(negedge clk);
        rst = r; start = s; key_l = kl; key_r = kr;
        raw[0] = kl; raw[1] = kr;
        if (r) begin
            mode = 0; pos = C; sl = 0; sr = 0; win = 0; held = 0; pl = 0; pr = 0;
            for (int k = 0; k < 2; k++) begin
                acc[k] = 0; prs[k] = 0;
                hist[k].delete();
                repeat (D + 1) hist[k].push_back(1'b0);
            end
        end else begin
            pl = 0; pr = 0;
            case (mode)
                0: if (s) mode = 1;
                1: begin
                    mv  = int'(prs[0]) - int'(prs[1]);
                    pos = pos + mv;
                    if (pos == N - 1) begin sl++; pl = 1; mode = 2; held = 0; end
                    else if (pos == 0) begin sr++; pr = 1; mode = 2; held = 0; end
                end
                2: begin
                    if (held == H) begin
                        if (sl == W) begin mode = 3; win = 1; end
                        else if (sr == W) begin mode = 3; win = 2; end
                        else begin mode = 1; pos = C; end
                    end else held++;
                end
                default: if (s) begin sl = 0; sr = 0; win = 0; pos = C; mode = 1; end
            endcase
            for (int k = 0; k < 2; k++) begin
                prs[k] = 1'b0;
                if (window_differs(k)) begin
                    acc[k] = ~acc[k];
                    prs[k] = acc[k];
                end
                hist[k].push_back(raw[k]);
                void'(hist[k].pop_front());
            end
        end
        e.st = 2'(mode); e.led = 7'(1 << pos); e.sl = 2'(sl); e.sr = 2'(sr);
        e.pl = pl; e.pr = pr; e.win = 2'(win);
        q.push_back(e);
    endtask

    task automatic keys(input bit kl, input bit kr, input int n);
        repeat (n) step(1'b0, 1'b0, kl, kr);
    endtask

    initial begin : monitor
        obs_t e, a;
        int   cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {state, led, score_l, score_r, point_l, point_r, winner};
                checks++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL outputs cyc=%0d got st=%b led=%b sl=%0d sr=%0d pl=%b pr=%b win=%b, expected st=%b led=%b sl=%0d sr=%0d pl=%b pr=%b win=%b",
                             cyc, a.st, a.led, a.sl, a.sr, a.pl, a.pr, a.win,
                             e.st, e.led, e.sl, e.sr, e.pl, e.pr, e.win);
                end
            end
        end
    end

    initial begin : driver
        int ll = 0, lr = 0;
        bit vl = 0, vr = 0;
        int tries;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        keys(0, 0, 3);
        keys(1, 0, 8);                  // clean left press
        keys(0, 0, 8);
        keys(1, 0, 3);                  // glitch below debounce length
        keys(0, 0, 8);
        repeat (3) begin keys(1, 0, 7); keys(0, 0, 7); end
        keys(0, 0, 12);
        keys(1, 1, 7);                  // simultaneous presses cancel
        keys(0, 0, 7);
        keys(0, 1, 7);
        keys(0, 0, 7);
        repeat (10) begin keys(0, 1, 7); keys(0, 0, 12); end
        keys(1, 0, 7);                  // ignored in DONE
        keys(0, 0, 7);
        step(0, 1, 0, 0);
        keys(0, 0, 4);

        for (int i = 0; i < 3000; i++) begin
            if (ll == 0) begin vl = 1'($urandom_range(0, 1)); ll = $urandom_range(1, 10); end
            if (lr == 0) begin vr = 1'($urandom_range(0, 1)); lr = $urandom_range(1, 10); end
            ll--; lr--;
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 19) == 0), vl, vr);
        end

        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        tries = 0;
        while (mode != 2 && tries < 20) begin
            keys(1, 0, 6);
            keys(0, 0, 6);
            tries++;
        end
        @(posedge clk);
        #2;
        checks++;
        if (state !== 2'b10) begin
            fails++;
            $display("FAIL reach_hold got state=%b expected 10", state);
        end
        step(1, 0, 0, 0);               // reset mid-HOLD
        keys(0, 0, 3);

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
